// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU; at most one transaction in flight.
// Define MEM_ARB_TIMEOUT_EN to force an error completion after TIMEOUT_CYCLES spent in REQ/WAIT.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp_err
);
    // state | meaning
    // IDLE  | nothing in flight; combinational grant to a valid requester
    // REQ   | mem_req_valid held with latched fields until mem_req_ready
    // WAIT  | waiting for mem_resp_valid
    // RESP  | one-cycle response pulse to the owner
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_lsu_q, owner_lsu_d;   // also serves as last_grant
    logic        mem_req_valid_q, mem_req_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic        ifu_resp_valid_q, ifu_resp_valid_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic        ifu_resp_err_q, ifu_resp_err_d;
    logic        lsu_resp_valid_q, lsu_resp_valid_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        lsu_resp_err_q, lsu_resp_err_d;

    logic        grant_any, grant_lsu;
    logic        done, done_err;
    logic [31:0] done_rdata;
    logic        timeout;

    assign grant_any     = ifu_req_valid || lsu_req_valid;
    assign grant_lsu     = lsu_req_valid && (!ifu_req_valid || !owner_lsu_q);
    assign ifu_req_ready = !rst && (state_q == IDLE) && ifu_req_valid && !grant_lsu;
    assign lsu_req_ready = !rst && (state_q == IDLE) && grant_lsu;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout = ((state_q == REQ) || (state_q == WAIT)) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = ((state_q == REQ) || (state_q == WAIT)) ? cnt_q + 1'b1 : '0;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        owner_lsu_d      = owner_lsu_q;
        mem_req_valid_d  = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_wen_d        = mem_wen_q;
        mem_wdata_d      = mem_wdata_q;
        mem_wmask_d      = mem_wmask_q;
        ifu_resp_valid_d = 1'b0;
        ifu_rdata_d      = ifu_rdata_q;
        ifu_resp_err_d   = ifu_resp_err_q;
        lsu_resp_valid_d = 1'b0;
        lsu_rdata_d      = lsu_rdata_q;
        lsu_resp_err_d   = lsu_resp_err_q;
        done             = 1'b0;
        done_err         = 1'b0;
        done_rdata       = '0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d         = REQ;
                    owner_lsu_d     = grant_lsu;
                    mem_req_valid_d = 1'b1;
                    if (grant_lsu) begin
                        mem_addr_d  = lsu_addr;
                        mem_wen_d   = lsu_wen;
                        mem_wdata_d = lsu_wdata;
                        mem_wmask_d = lsu_wmask;
                    end else begin
                        mem_addr_d  = ifu_addr;
                        mem_wen_d   = 1'b0;
                        mem_wdata_d = '0;
                        mem_wmask_d = '0;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else if (timeout) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    mem_req_valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    done       = 1'b1;
                    done_err   = mem_resp_err;
                    done_rdata = mem_wen_q ? '0 : mem_rdata;
                end else if (timeout) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d = RESP;
            if (owner_lsu_q) begin
                lsu_resp_valid_d = 1'b1;
                lsu_rdata_d      = done_rdata;
                lsu_resp_err_d   = done_err;
            end else begin
                ifu_resp_valid_d = 1'b1;
                ifu_rdata_d      = done_rdata;
                ifu_resp_err_d   = done_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            owner_lsu_q      <= 1'b0;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= '0;
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            ifu_resp_err_q   <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            lsu_rdata_q      <= '0;
            lsu_resp_err_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q            <= '0;
`endif
        end else begin
            state_q          <= state_d;
            owner_lsu_q      <= owner_lsu_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_wen_q        <= mem_wen_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_wmask_q      <= mem_wmask_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            ifu_rdata_q      <= ifu_rdata_d;
            ifu_resp_err_q   <= ifu_resp_err_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            lsu_rdata_q      <= lsu_rdata_d;
            lsu_resp_err_q   <= lsu_resp_err_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q            <= cnt_d;
`endif
        end
    end

    assign mem_req_valid  = mem_req_valid_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wen        = mem_wen_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wmask      = mem_wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign ifu_resp_err   = ifu_resp_err_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign lsu_resp_err   = lsu_resp_err_q;

endmodule
